// File: rtl/fifo_11b_drain_packer_if.sv
// Stream bundle for the drain packer: show-ahead FIFO read side plus the packed
// output beat channel. master = packer side, slave = FIFO/downstream side.
interface fifo_11b_drain_packer_if #(
  parameter int PACK_N = 4
) ();
  logic [10:0]          fifo_q;
  logic                 fifo_empty;
  logic                 fifo_rdreq;
  logic                 out_valid;
  logic                 out_ready;
  logic [PACK_N*11-1:0] out_data;
  logic [PACK_N-1:0]    out_keep;
  logic                 out_last;

  modport master (
    input  fifo_q, fifo_empty, out_ready,
    output fifo_rdreq, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    output fifo_q, fifo_empty, out_ready,
    input  fifo_rdreq, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/fifo_11b_drain_packer.sv
// Drains an 11-bit show-ahead FIFO and packs up to PACK_N words per output beat,
// flushing on eop (bit 10) or idle timeout. FIFO_11B_DRAIN_PACKER_STATS_EN adds beat/stall counters.
module fifo_11b_drain_packer #(
  parameter int PACK_N        = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                          clock,
  input  logic                          sclr,
  fifo_11b_drain_packer_if.master       bus,
  output logic                          busy
`ifdef FIFO_11B_DRAIN_PACKER_STATS_EN
  ,
  output logic [31:0]                   stat_beats,
  output logic [31:0]                   stat_stalls
`endif
);
  localparam int          CW       = $clog2(PACK_N + 1);
  localparam bit          TO_EN    = (FLUSH_TIMEOUT != 0);
  localparam logic [15:0] IDLE_MAX = 16'(FLUSH_TIMEOUT > 0 ? FLUSH_TIMEOUT - 1 : 0);

  logic [PACK_N-1:0][10:0] lanes;
  logic [CW-1:0]           count, base_count;
  logic                    acc_last, acc_done;
  logic [15:0]             idle_cnt;
  logic                    xfer, pop, timeout_hit;
  logic [PACK_N-1:0]       keep_now;

  assign xfer           = acc_done && (!bus.out_valid || bus.out_ready);
  assign pop            = !sclr && !bus.fifo_empty && (!acc_done || xfer);
  assign bus.fifo_rdreq = pop;
  // A word popped alongside a transfer starts the fresh accumulator at lane 0.
  assign base_count     = xfer ? '0 : count;
  assign timeout_hit    = TO_EN && (count != '0) && !acc_done && !pop && (idle_cnt == IDLE_MAX);
  assign busy           = (count != '0) || bus.out_valid;

  always_comb begin
    keep_now = '0;
    for (int i = 0; i < PACK_N; i++) keep_now[i] = (CW'(i) < count);
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      lanes         <= '0;
      count         <= '0;
      acc_last      <= 1'b0;
      acc_done      <= 1'b0;
      idle_cnt      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_keep  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      if (xfer) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= lanes;
        bus.out_keep  <= keep_now;
        bus.out_last  <= acc_last;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (pop) begin
        for (int i = 0; i < PACK_N; i++) begin
          if (base_count == CW'(i)) lanes[i] <= bus.fifo_q;
          else if (xfer)            lanes[i] <= '0;
        end
        count    <= base_count + 1'b1;
        acc_done <= (base_count == CW'(PACK_N - 1)) || bus.fifo_q[10];
        acc_last <= bus.fifo_q[10];
        idle_cnt <= '0;
      end else if (xfer) begin
        lanes    <= '0;
        count    <= '0;
        acc_done <= 1'b0;
        acc_last <= 1'b0;
        idle_cnt <= '0;
      end else if (timeout_hit) begin
        acc_done <= 1'b1;
        idle_cnt <= '0;
      end else if ((count != '0) && !acc_done) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

`ifdef FIFO_11B_DRAIN_PACKER_STATS_EN
  always_ff @(posedge clock) begin
    if (sclr) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready)  stat_beats  <= stat_beats + 32'd1;
      if (bus.out_valid && !bus.out_ready) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: doc/fifo_11b_drain_packer.md
Name: fifo_11b_drain_packer

Overview:
- Downstream consumer of the 11-bit, 256-word show-ahead CDC FIFO.
- Pops words whenever the FIFO is non-empty and there is room, then packs up to PACK_N words into one wide beat.
- Presents each beat on a valid/ready stream toward the bloom-filter request path.
- Flushes a partial beat on an end-of-packet flag (word bit 10) or after an idle timeout.

Parameters:
- PACK_N, 4: words per output beat; legal range 2..8.
- FLUSH_TIMEOUT, 16: idle cycles before a partial beat is flushed. 0 disables the timeout; legal range 0..65535.

Ports:
- clock  in  1  rising-edge clock, same domain as the FIFO read side
- sclr  in  1  synchronous, active-high reset
- fifo_q  in  11  show-ahead FIFO head word; bit 10 = eop, bits 9:0 = payload
- fifo_empty  in  1  FIFO empty flag
- fifo_rdreq  out  1  FIFO pop request (combinational)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  PACK_N*11  packed words; lane 0 in bits 10:0
- out_keep  out  PACK_N  lane-valid mask; always contiguous from lane 0
- out_last  out  1  beat ends with an eop word
- busy  out  1  accumulator or output register holds data

Behaviour:
- Reset:
  - All state is cleared on a clock edge with sclr=1.
  - out_valid=0, out_data=0, out_keep=0, out_last=0, busy=0.
  - fifo_rdreq is forced to 0 while sclr=1.
  - FIFO contents are not touched.
  - Asserting sclr mid-packet discards any partial accumulator and any pending beat.
- Storage:
  - Accumulator: PACK_N x 11-bit lanes, a count (0..PACK_N), an acc_last bit and an acc_done flag.
  - One output register.
- Transfer and pop:
  - xfer = acc_done && (!out_valid || out_ready).
  - fifo_rdreq = !sclr && !fifo_empty && (!acc_done || xfer).
- Pop cycle:
  - fifo_q is written into lane [count] and count increments.
  - If xfer occurs in the same cycle, the word goes to lane 0 of the fresh accumulator (count becomes 1).
- acc_done is set at the end of the pop cycle when:
  - the new count equals PACK_N, or
  - fifo_q[10]=1 (eop); acc_last is set with it.
- Timeout:
  - A 16-bit idle counter increments each cycle with count>0, !acc_done and no pop. It clears on a pop or on xfer.
  - When it reaches FLUSH_TIMEOUT-1, acc_done is set and acc_last stays 0.
  - No effect when FLUSH_TIMEOUT=0.
- On xfer:
  - out_data = accumulator lanes; unused lanes are 0.
  - out_keep = (1<<count)-1; out_last = acc_last; out_valid=1.
  - Accumulator clears.
- Output handshake:
  - out_valid && out_ready with no xfer in the same cycle: out_valid drops to 0 next cycle.
  - out_data, out_keep and out_last are held stable while out_valid && !out_ready.
- Latency:
  - A word that completes a beat in cycle N yields out_valid in cycle N+2 when the output register is free.
  - Sustained throughput is one word per cycle; back-pressure stalls popping only once acc_done is set.
- Empty FIFO: no pop and no fabrication. fifo_q is ignored when fifo_empty=1.
- busy = (count>0) || out_valid.

Optional Feature:
- Macro: FIFO_11B_DRAIN_PACKER_STATS_EN.
- When defined, two extra output ports are added:
  - stat_beats [31:0]: increments on each out_valid && out_ready.
  - stat_stalls [31:0]: increments on each cycle with out_valid && !out_ready.
- Both counters wrap at 2^32, clear on sclr and update one cycle after the event.
- When not defined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold sclr 3 cycles with fifo_empty=0 -> fifo_rdreq=0 throughout; after release out_valid=0, out_keep=0, busy=0.
- Full pack: 4 words 0x001..0x004 without eop, out_ready=1 -> one beat with out_data = {0x004,0x003,0x002,0x001}, out_keep=4'b1111, out_last=0, out_valid 2 cycles after the 4th pop.
- EOP flush: words 0x011 then 0x412 (eop) -> beat with out_keep=4'b0011, out_last=1, lanes 2-3 zero.
- Timeout: single word 0x055 then FIFO empty, FLUSH_TIMEOUT=16 -> beat with out_keep=4'b0001, out_last=0, emitted after 16 idle cycles.
- Back-pressure: 12 words, out_ready=0 for 20 cycles:
  - fifo_rdreq stops after 8 pops (one beat held, one accumulator done).
  - out_data stays stable.
  - On release, 3 beats arrive in order with no loss; stat_beats=3 and stat_stalls=20 when FIFO_11B_DRAIN_PACKER_STATS_EN is defined.
- Mid-packet reset: sclr pulsed after 2 of 4 words -> no beat emitted; the next 4 words form a clean beat starting at lane 0.
